// File: rtl/imem_responder_if.sv
// Request/response bundle between the fetch stage (master) and the instruction memory (slave).
interface imem_responder_if;
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_spec;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_fence, mem_spec, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_fence, mem_spec, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: word RAM behind a fixed-latency response pipeline,
// with speculative flush and a fence invalidate window.
module imem_responder #(
    parameter int unsigned DEPTH        = 4096,
    parameter int unsigned LATENCY      = 2,
    parameter int unsigned FENCE_CYCLES = 4
) (
    input  logic            clock,
    input  logic            reset,
    imem_responder_if.slave imem
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic {
        RUN,
        FENCE
    } state_t;

    state_t             state;
    logic [3:0]         fence_cnt;
    logic [IDX_W-1:0]   fence_idx;
    logic [LATENCY-1:0] pipe_vld;
    logic [31:0]        pipe_data [LATENCY];

    logic [31:0]        ram [DEPTH];

    logic [IDX_W-1:0]   req_idx;
    logic [IDX_W-1:0]   rd_idx;
    logic               accept;
    logic               do_fence;
    logic               do_write;
    logic               flush;
    logic               fence_ins;
    logic               ins_valid;
    logic [31:0]        ins_data;

    // Low address bits, high address bits and the instruction flag carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{imem.mem_instr, imem.mem_addr[31:IDX_W+2], imem.mem_addr[1:0]};

    always_comb begin
        req_idx   = imem.mem_addr[IDX_W+1:2];
        accept    = imem.mem_valid && (state == RUN);
        do_fence  = accept && imem.mem_fence;
        do_write  = accept && !imem.mem_fence && (imem.mem_wstrb != '0);
        flush     = accept && (imem.mem_fence || imem.mem_spec);
        fence_ins = (state == FENCE) && (fence_cnt == '0);
        ins_valid = (accept && !imem.mem_fence) || fence_ins;
        rd_idx    = fence_ins ? fence_idx : req_idx;
        // Writes answer with zero data; the RAM read sees the pre-write contents.
        ins_data  = (ins_valid && !do_write) ? ram[rd_idx] : '0;
    end

    always_ff @(posedge clock) begin
        if (do_write) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (imem.mem_wstrb[b]) begin
                    ram[req_idx][8*b +: 8] <= imem.mem_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            fence_cnt <= '0;
            fence_idx <= '0;
            pipe_vld  <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            // Stage 0 always takes the new entry, so a flush only clears the older stages.
            pipe_vld[0]  <= ins_valid;
            pipe_data[0] <= ins_data;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                pipe_vld[i]  <= flush ? 1'b0 : pipe_vld[i-1];
                pipe_data[i] <= flush ? '0   : pipe_data[i-1];
            end

            case (state)
                RUN: begin
                    if (do_fence) begin
                        fence_idx <= req_idx;
                        fence_cnt <= 4'(FENCE_CYCLES - 1);
                        state     <= FENCE;
                    end
                end
                FENCE: begin
                    if (fence_cnt == '0) begin
                        state <= RUN;
                    end else begin
                        fence_cnt <= fence_cnt - 4'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign imem.mem_ready = pipe_vld[LATENCY-1];
    assign imem.mem_rdata = pipe_data[LATENCY-1];

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder (LATENCY=2, FENCE_CYCLES=4, DEPTH=4096).
module tb_imem_responder;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    imem_responder_if bus ();

    imem_responder #(
        .DEPTH        (4096),
        .LATENCY      (2),
        .FENCE_CYCLES (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .imem  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic rdy, input logic [31:0] data);
        check({tag, ".rdy"},   {31'b0, bus.mem_ready}, {31'b0, rdy});
        check({tag, ".rdata"}, bus.mem_rdata, data);
    endtask

    task automatic drive(input logic v, input logic f, input logic s,
                         input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
        bus.mem_valid = v;
        bus.mem_fence = f;
        bus.mem_spec  = s;
        bus.mem_instr = 1'b1;
        bus.mem_addr  = a;
        bus.mem_wdata = wd;
        bus.mem_wstrb = st;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic rd(input logic [31:0] a);
        drive(1'b1, 1'b0, 1'b0, a, 32'h0, 4'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
        drive(1'b1, 1'b0, 1'b0, a, d, st);
    endtask

    // One active edge, then settle to the falling edge where outputs are sampled.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drain();
        idle();
        repeat (4) step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        idle();
        repeat (2) step();
        expect_out("reset", 1'b0, 32'h0);
        reset = 1'b0;

        // Test 1: preload word 5, then read it plainly and through an aliased address.
        wr(32'h14, 32'hDEADBEEF, 4'hF);
        step();
        drain();
        rd(32'h14);
        step();
        expect_out("t1.before", 1'b0, 32'h0);
        rd(32'hFFFF_4016);
        step();
        expect_out("t1.rd14", 1'b1, 32'hDEADBEEF);
        idle();
        step();
        expect_out("t1.wrap", 1'b1, 32'hDEADBEEF);
        step();
        expect_out("t1.after", 1'b0, 32'h0);

        // Test 2: eight back-to-back reads of preloaded 0..7.
        for (int i = 0; i < 8; i++) begin
            wr(32'(4 * i), 32'(i), 4'hF);
            step();
        end
        drain();
        for (int i = 0; i < 8; i++) begin
            rd(32'(4 * i));
            step();
            if (i > 0) expect_out($sformatf("t2.s%0d", i - 1), 1'b1, 32'(i - 1));
        end
        idle();
        step();
        expect_out("t2.s7", 1'b1, 32'd7);
        step();
        expect_out("t2.end", 1'b0, 32'h0);

        // Test 3: spec read flushes the 0x4 response.
        wr(32'h0, 32'hCAFE0000, 4'hF);
        step();
        wr(32'h4, 32'hCAFE0001, 4'hF);
        step();
        wr(32'h40, 32'h40404040, 4'hF);
        step();
        wr(32'h100, 32'h0F0F0100, 4'hF);
        step();
        drain();
        rd(32'h0);
        step();
        expect_out("t3.e0", 1'b0, 32'h0);
        rd(32'h4);
        step();
        expect_out("t3.r0", 1'b1, 32'hCAFE0000);
        drive(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 4'h0);
        step();
        expect_out("t3.no4", 1'b0, 32'h0);
        idle();
        step();
        expect_out("t3.r40", 1'b1, 32'h40404040);
        step();
        expect_out("t3.end", 1'b0, 32'h0);

        // Test 4: fence window drops N+1..N+4, fence response and N+5 read follow.
        drive(1'b1, 1'b1, 1'b1, 32'h100, 32'h0, 4'h0);
        step();
        expect_out("t4.n", 1'b0, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 1'b0, (k == 2), 32'h0, 32'h0, 4'h0);
            step();
            expect_out($sformatf("t4.drop%0d", k), 1'b0, 32'h0);
        end
        rd(32'h4);
        step();
        expect_out("t4.fence", 1'b1, 32'h0F0F0100);
        idle();
        step();
        expect_out("t4.n5", 1'b1, 32'hCAFE0001);
        step();
        expect_out("t4.end", 1'b0, 32'h0);

        // Test 5: write responses carry zero, byte strobes merge correctly.
        wr(32'h8, 32'h11223344, 4'hF);
        step();
        expect_out("t5.w0", 1'b0, 32'h0);
        wr(32'h8, 32'h000000AA, 4'h1);
        step();
        expect_out("t5.w0rsp", 1'b1, 32'h0);
        rd(32'h8);
        step();
        expect_out("t5.w1rsp", 1'b1, 32'h0);
        wr(32'h8, 32'hFFFFFFFF, 4'h6);
        step();
        expect_out("t5.rd", 1'b1, 32'h112233AA);
        rd(32'h8);
        step();
        expect_out("t5.w2rsp", 1'b1, 32'h0);
        idle();
        step();
        expect_out("t5.rd2", 1'b1, 32'h11FFFFAA);
        step();
        expect_out("t5.end", 1'b0, 32'h0);

        // Test 6a: reset kills a visible response without a clock edge.
        rd(32'h4);
        step();
        idle();
        step();
        expect_out("t6.vis", 1'b1, 32'hCAFE0001);
        #1 reset = 1'b1;
        #1 expect_out("t6.async", 1'b0, 32'h0);
        step();
        reset = 1'b0;

        // Test 6b: reset two cycles into a fence window discards it.
        drive(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        step();
        idle();
        step();
        step();
        #1 reset = 1'b1;
        #1 expect_out("t6.fenrst", 1'b0, 32'h0);
        step();
        reset = 1'b0;
        rd(32'h4);
        step();
        expect_out("t6.lat", 1'b0, 32'h0);
        idle();
        step();
        expect_out("t6.rd", 1'b1, 32'hCAFE0001);
        for (int k = 0; k < 6; k++) begin
            step();
            expect_out($sformatf("t6.quiet%0d", k), 1'b0, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder: the slave end of the `imem_in`/`imem_out` request interface driven by the fetch stage. It holds a word-organised on-chip RAM and accepts one request per cycle. Read data returns after a fixed, parameterised latency. Speculative (redirect) requests discard all in-flight responses, and fence requests stall the block for a fixed invalidate window before they are serviced. It sits between the fetch stage and the instruction RAM in the core's top level.

## Interface
- `DEPTH`, 4096: RAM size in 32-bit words; power of two; index = `mem_addr[log2(DEPTH)+1:2]`.
- `LATENCY`, 2: cycles from acceptance to response; legal range 1..4.
- `FENCE_CYCLES`, 4: invalidate window length; legal range 1..15.
- `clock`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state except RAM contents.
- `imem_in`  input  `mem_in_type`  request bundle with these fields:
  - `mem_valid` (1)
  - `mem_fence` (1)
  - `mem_spec` (1)
  - `mem_instr` (1, ignored)
  - `mem_addr` (32)
  - `mem_wdata` (32)
  - `mem_wstrb` (4)
- `imem_out`  output  `mem_out_type`  response bundle with these fields:
  - `mem_ready` (1): one-cycle pulse marking a valid response.
  - `mem_rdata` (32): response data.

## Operation
- States: RUN, FENCE.
- **RUN, acceptance:** a request is accepted in any cycle where `mem_valid=1`. No backpressure exists in RUN.
- **RUN, write** (`mem_wstrb≠0`):
  - Byte-enabled RAM write at the edge; `mem_wstrb[i]` writes byte i.
  - The write produces a response like a read, with `mem_rdata=0`.
- **RUN, read:** the read enters a LATENCY-deep response pipeline with a valid bit per stage.
- **Speculative request** (`mem_spec=1`, `mem_fence=0`): at the accepting edge all pipeline valid bits are cleared, then the new request is inserted. Responses belonging to older requests never appear.
- **Fence request** (`mem_fence=1`; `mem_spec` is don't-care, fence takes priority):
  - The pipeline is cleared and `mem_addr` is latched.
  - A 4-bit counter loads `FENCE_CYCLES-1` and the state goes to FENCE.
- **FENCE:**
  - All `mem_valid` requests are ignored and dropped; there are no responses for them. This applies to spec requests too.
  - The counter decrements each cycle.
  - On the cycle the counter is 0, a read of the latched address is inserted into the pipeline and the state returns to RUN.
- **Address handling:**
  - `mem_addr[1:0]` is ignored.
  - Addresses beyond DEPTH wrap modulo DEPTH; high bits are ignored.
- **Read/write same cycle, same address:** read returns old data; reads are read-before-write.
- **RAM:** contents are not cleared by reset. An optional `$readmemh` init is controlled by a `+define` on the simulation command line.

## Timing
- **Reset values:**
  - `mem_ready=0`, `mem_rdata=0`.
  - State RUN, counter 0, all pipeline valid bits 0.
  - Pipeline contents are held at 0 during reset.
- **Request latency:** request accepted at edge N → `mem_ready=1` with data valid during the cycle after edge N+LATENCY-1.
  - LATENCY=1: response visible in the cycle following acceptance.
- **Throughput:**
  - Back-to-back requests produce back-to-back responses in order.
  - Maximum throughput is one response per cycle.
- **`mem_rdata`** is 0 whenever `mem_ready=0`.
- **Fence latency:** fence accepted at edge N → response at edge N+FENCE_CYCLES+LATENCY.
  - Requests at edges N+1 … N+FENCE_CYCLES are dropped.
  - A request at edge N+FENCE_CYCLES+1 is accepted normally.
- **Spec and in-flight responses:** a spec request at edge N suppresses any response that would have appeared at or after edge N. A response already visible during the cycle of edge N is unaffected.
- **Reset mid-operation:** asserting `reset` asynchronously forces `mem_ready=0` immediately. All in-flight requests and any pending fence are discarded.

## Test plan
1. **Reset / basic read:**
   - Preload word 5 = 0xDEADBEEF.
   - Deassert reset, read addr 0x14 with LATENCY=2.
   - → `mem_ready=1`, `mem_rdata=0xDEADBEEF` exactly 2 cycles after acceptance; outputs 0 before that.
2. **Streaming:**
   - 8 consecutive reads of 0x0, 0x4, … 0x1C, preloaded with values 0..7.
   - → 8 consecutive ready pulses carrying 0..7 in order, no gaps.
3. **Spec flush:**
   - Read 0x0 then 0x4.
   - Then read 0x40 with `mem_spec=1` one cycle after the 0x4 read.
   - → only responses for 0x0 (if already due) and 0x40 appear; the 0x4 response is never seen.
4. **Fence:**
   - `FENCE_CYCLES=4`, LATENCY=2.
   - Fence request at 0x100 at edge N, with reads issued at N+1..N+4.
   - → a single response for 0x100 at N+6; no responses for the dropped reads; a read at N+5 is answered at N+7.
5. **Write then read:**
   - Write 0x11223344 to 0x8 with `wstrb=0xF`.
   - Then write 0xAA with `wstrb=0x1`.
   - Then read 0x8.
   - → write responses carry rdata=0; read returns 0x112233AA.
6. **Async reset mid-fence:**
   - Assert `reset` 2 cycles into a fence window.
   - → `mem_ready=0` immediately; after release the state is RUN and the next read is answered with normal latency.
   - → The fenced address produces no response.
